// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the byte-serial instruction fetcher.
//   fetch_state_t  - sequencer state encoding
//   byte_idx_t     - index of the instruction byte currently being fetched
//   INST_BYTES     - bytes per instruction
//   fetch_addr_ok  - legality check for an instruction fetch address
package fetch_pkg;

  localparam int unsigned INST_BYTES = 4;

  typedef logic [1:0] byte_idx_t;

  // ST_BOOT only exists while reset is applied and for the first edge after
  // release, so that mem_req and busy stay low during reset.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  // Word aligned and the whole word inside memory. The compare is done in
  // 65 bits so addresses near 2^64 cannot wrap into range.
  function automatic logic fetch_addr_ok(input logic [63:0] addr,
                                         input logic [63:0] mem_bytes);
    return (addr[1:0] == 2'b00) &&
           (({1'b0, addr} + 65'(INST_BYTES - 1)) < {1'b0, mem_bytes});
  endfunction

endpackage

// File: rtl/inst_byte_assembler.sv
// inst_byte_assembler: 32-bit instruction register written one byte lane at a
// time (little-endian lanes), with synchronous clear.
//   clk, rst_n - clock, asynchronous active-low reset (clears word)
//   clr        - clear word to zero (wins over we)
//   we         - write wdata into lane
//   lane       - byte lane 0..3
//   wdata      - byte to write
//   word       - assembled instruction
module inst_byte_assembler
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        we,
  input  byte_idx_t   lane,
  input  logic [7:0]  wdata,
  output logic [31:0] word
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (clr) begin
      word <= '0;
    end else if (we) begin
      word[{lane, 3'b000} +: 8] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 32-bit instructions over a byte-wide memory port,
// assembles them little-endian and offers them to decode with a valid/ready
// handshake. Redirects load a new PC from any state; illegal addresses park
// the sequencer in FAULT until a legal redirect or reset.
//   clk, rst_n     - clock, asynchronous active-low reset
//   redirect_valid - load redirect_addr as the new PC
//   redirect_addr  - new PC
//   mem_req        - byte read request (FETCH only)
//   mem_addr       - byte address, pc + byte index
//   mem_ack        - byte accepted, mem_rdata valid this cycle
//   mem_rdata      - read byte
//   inst_valid     - assembled instruction available (HOLD)
//   inst_ready     - decode accepts inst
//   inst, inst_pc  - instruction and its PC
//   fault          - illegal fetch address (FAULT)
//   busy           - high while fetching
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [63:0] MEM_BYTES = 64'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_addr,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        fault,
  output logic        busy
);

  fetch_state_t state;
  logic [63:0]  pc;
  byte_idx_t    byte_idx;

  logic         take_byte;
  logic         last_byte;
  logic         handshake;
  logic [63:0]  pc_seq;

  // A redirect cancels any byte acked in the same cycle.
  assign take_byte = (state == ST_FETCH) && mem_ack && !redirect_valid;
  assign last_byte = (byte_idx == byte_idx_t'(INST_BYTES - 1));
  assign handshake = (state == ST_HOLD) && inst_ready;
  assign pc_seq    = pc + 64'(INST_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      byte_idx <= '0;
    end else if (redirect_valid) begin
      // Also covers a same-cycle HOLD handshake: the transfer completes,
      // but the redirect target wins over pc+4.
      pc       <= redirect_addr;
      byte_idx <= '0;
      state    <= fetch_addr_ok(redirect_addr, MEM_BYTES) ? ST_FETCH : ST_FAULT;
    end else begin
      unique case (state)
        ST_BOOT: begin
          state <= fetch_addr_ok(pc, MEM_BYTES) ? ST_FETCH : ST_FAULT;
        end
        ST_FETCH: begin
          if (take_byte) begin
            byte_idx <= byte_idx + 2'd1;
            if (last_byte) begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (handshake) begin
            pc       <= pc_seq;
            byte_idx <= '0;
            state    <= fetch_addr_ok(pc_seq, MEM_BYTES) ? ST_FETCH : ST_FAULT;
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_FAULT;
        end
      endcase
    end
  end

  // Every lane is rewritten before inst_valid, so partial bytes from an
  // aborted fetch can never leak; clearing on redirect just keeps inst tidy.
  inst_byte_assembler u_asm (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (redirect_valid),
    .we    (take_byte),
    .lane  (byte_idx),
    .wdata (mem_rdata),
    .word  (inst)
  );

  assign mem_req    = (state == ST_FETCH);
  assign busy       = (state == ST_FETCH);
  assign mem_addr   = pc + {62'd0, byte_idx};
  assign inst_valid = (state == ST_HOLD);
  assign inst_pc    = pc;
  assign fault      = (state == ST_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_addr;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        fault;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  exp_t        sb[$];
  logic [7:0]  mem [16];
  logic        gap_mode = 1'b0;
  int unsigned ack_count = 0;
  int unsigned req_seen  = 0;

  fetch_sequencer #(.RESET_PC(64'h0), .MEM_BYTES(64'd16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fault          (fault),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic [31:0] word);
    exp_t e;
    e.pc   = pc;
    e.inst = word;
    sb.push_back(e);
  endtask

  task automatic do_redirect(input logic [63:0] addr);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_addr  = addr;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  // Every sequence ends in FAULT after pc walks off the end of memory.
  task automatic wait_done(input string tag);
    int unsigned n = 0;
    while (!(fault && sb.size() == 0) && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_fault"}, 64'(fault), 64'd1);
    check_eq({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    while (!inst_valid && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_valid_seen"}, 64'(inst_valid), 64'd1);
  endtask

  // Memory responder: acks requests (optionally after random gaps) and checks
  // that the request address does not move while a request is outstanding.
  initial begin
    int unsigned wait_cnt = 0;
    logic        pend     = 1'b0;
    logic        rd_last  = 1'b1;
    logic [63:0] last_addr = '0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && pend && mem_req && !rd_last)
        check_eq("mem_addr_stable", mem_addr, last_addr);
      if (mem_req) req_seen++;
      if (mem_req && rst_n) begin
        if (wait_cnt > 0) begin
          wait_cnt--;
          mem_ack = 1'b0;
        end else begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr[3:0]];
          ack_count++;
          wait_cnt  = gap_mode ? $urandom_range(0, 3) : 0;
        end
      end else begin
        mem_ack = 1'b0;
      end
      pend      = mem_req && !mem_ack;
      last_addr = mem_addr;
      #1;
      rd_last = redirect_valid || !rst_n;
    end
  end

  // Scoreboard monitor: every accepted instruction must match the oldest
  // expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && inst_valid && inst_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_has_entry", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check_eq("inst", 64'(inst), 64'(e.inst));
          check_eq("inst_pc", inst_pc, e.pc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned cycles;
    int unsigned req_base;
    int unsigned ack_base;
    logic [31:0] cap_inst;
    logic [63:0] cap_pc;

    mem[0]  = 8'h83; mem[1]  = 8'h34; mem[2]  = 8'h85; mem[3]  = 8'h02;
    mem[4]  = 8'hb3; mem[5]  = 8'h84; mem[6]  = 8'h9a; mem[7]  = 8'h00;
    mem[8]  = 8'h13; mem[9]  = 8'h05; mem[10] = 8'h10; mem[11] = 8'h00;
    mem[12] = 8'h6f; mem[13] = 8'h00; mem[14] = 8'h00; mem[15] = 8'h00;

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    inst_ready     = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_fault", 64'(fault), 64'd0);
    check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
    check_eq("rst_inst", 64'(inst), 64'd0);
    check_eq("rst_inst_pc", inst_pc, 64'd0);

    // Straight-line fetch from reset, ack every cycle, runs off the end
    push_exp(64'd0,  32'h02853483);
    push_exp(64'd4,  32'h009A84B3);
    push_exp(64'd8,  32'h00100513);
    push_exp(64'd12, 32'h0000006F);
    @(negedge clk);
    rst_n  = 1'b1;
    cycles = 0;
    while (!inst_valid && cycles < 50) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    check_eq("first_valid_latency", 64'(cycles), 64'd5);
    wait_done("seq");
    check_eq("end_mem_req", 64'(mem_req), 64'd0);
    check_eq("end_busy", 64'(busy), 64'd0);
    check_eq("end_inst_valid", 64'(inst_valid), 64'd0);
    check_eq("end_pc", inst_pc, 64'd16);
    req_base = req_seen;
    repeat (10) @(negedge clk);
    check_eq("end_no_req", 64'(req_seen - req_base), 64'd0);

    // Misaligned redirect faults; legal redirect recovers
    do_redirect(64'd6);
    #1;
    check_eq("mis_fault", 64'(fault), 64'd1);
    req_base = req_seen;
    repeat (8) @(negedge clk);
    #1;
    check_eq("mis_no_req", 64'(req_seen - req_base), 64'd0);
    check_eq("mis_fault_held", 64'(fault), 64'd1);
    push_exp(64'd12, 32'h0000006F);
    do_redirect(64'd12);
    #1;
    check_eq("rec_fault", 64'(fault), 64'd0);
    check_eq("rec_busy", 64'(busy), 64'd1);
    check_eq("rec_mem_addr", mem_addr, 64'd12);
    wait_done("rec");

    // Random ack gaps and decode back-pressure
    gap_mode   = 1'b1;
    inst_ready = 1'b0;
    push_exp(64'd0,  32'h02853483);
    push_exp(64'd4,  32'h009A84B3);
    push_exp(64'd8,  32'h00100513);
    push_exp(64'd12, 32'h0000006F);
    do_redirect(64'd0);
    wait_valid("bp");
    cap_inst = inst;
    cap_pc   = inst_pc;
    repeat (5) begin
      @(negedge clk);
      #1;
      check_eq("hold_inst", 64'(inst), 64'(cap_inst));
      check_eq("hold_pc", inst_pc, cap_pc);
      check_eq("hold_no_req", 64'(mem_req), 64'd0);
      check_eq("hold_valid", 64'(inst_valid), 64'd1);
    end
    inst_ready = 1'b1;
    wait_done("bp");
    gap_mode = 1'b0;

    // Redirect during byte 2 with a same-cycle ack
    push_exp(64'd8,  32'h00100513);
    push_exp(64'd12, 32'h0000006F);
    do_redirect(64'd0);
    cycles = 0;
    while (!(mem_req && mem_addr == 64'd2) && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    check_eq("mid_addr2_seen", mem_addr, 64'd2);
    redirect_valid = 1'b1;
    redirect_addr  = 64'd8;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check_eq("mid_next_addr", mem_addr, 64'd8);
    check_eq("mid_req", 64'(mem_req), 64'd1);
    check_eq("mid_valid", 64'(inst_valid), 64'd0);
    wait_done("mid");

    // Redirect in the same cycle as the HOLD handshake
    inst_ready = 1'b0;
    push_exp(64'd0,  32'h02853483);
    push_exp(64'd12, 32'h0000006F);
    do_redirect(64'd0);
    wait_valid("hsr");
    @(negedge clk);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 64'd12;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check_eq("hsr_pc", inst_pc, 64'd12);
    check_eq("hsr_addr", mem_addr, 64'd12);
    check_eq("hsr_valid", 64'(inst_valid), 64'd0);
    wait_done("hsr");

    // Reset in the middle of a fetch
    do_redirect(64'd4);
    ack_base = ack_count;
    cycles   = 0;
    while (ack_count - ack_base < 2 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_mem_req", 64'(mem_req), 64'd0);
    check_eq("mrst_inst", 64'(inst), 64'd0);
    check_eq("mrst_valid", 64'(inst_valid), 64'd0);
    check_eq("mrst_busy", 64'(busy), 64'd0);
    check_eq("mrst_pc", inst_pc, 64'd0);
    push_exp(64'd0,  32'h02853483);
    push_exp(64'd4,  32'h009A84B3);
    push_exp(64'd8,  32'h00100513);
    push_exp(64'd12, 32'h0000006F);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("mrst_restart_addr", mem_addr, 64'd0);
    check_eq("mrst_restart_req", 64'(mem_req), 64'd1);
    wait_done("mrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
